// File: rtl/branch_pkg.sv
// Shared types, constants and the saturating-counter helper for the branch controller.
// Optional statistics counters are enabled with the BRANCH_STATS_EN macro.
package branch_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned BHT_IDX_W_DEF = 6;
    localparam int unsigned FLUSH_CYC_DEF = 2;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_SNT = 2'b00;
    localparam bht_cnt_t BHT_WNT = 2'b01;
    localparam bht_cnt_t BHT_WT  = 2'b10;
    localparam bht_cnt_t BHT_ST  = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        FLUSH    = 2'd2
    } brctl_state_t;

    // Two-bit saturating counter step toward the resolved outcome
    function automatic bht_cnt_t bht_next(input bht_cnt_t cur, input logic taken);
        if (taken) begin
            return (cur == BHT_ST) ? BHT_ST : bht_cnt_t'(cur + 2'd1);
        end
        return (cur == BHT_SNT) ? BHT_SNT : bht_cnt_t'(cur - 2'd1);
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch/execute/redirect bundle between the pipeline and the branch controller.
// Optional statistics outputs (BRANCH_STATS_EN) live on the controller, not here.
interface branch_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic            if_pred_taken;

    logic            ex_valid;
    logic            ex_branch;
    logic [XLEN-1:0] ex_pc;
    logic            ex_pred_taken;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;

    modport master (
        output if_valid, if_pc,
        output ex_valid, ex_branch, ex_pc, ex_pred_taken, ex_taken, ex_target,
        input  if_pred_taken, redirect_valid, redirect_pc, flush
    );

    modport slave (
        input  if_valid, if_pc,
        input  ex_valid, ex_branch, ex_pc, ex_pred_taken, ex_taken, ex_target,
        output if_pred_taken, redirect_valid, redirect_pc, flush
    );
endinterface

// File: rtl/branch_ctrl_bht_array.sv
// Branch history table: async read port, sync saturating-update port, async reset to weakly not-taken.
// Used by branch_ctrl in every build, with or without BRANCH_STATS_EN.
module bht_array
    import branch_pkg::*;
#(
    parameter int unsigned IDX_W = 6
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_t         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    bht_cnt_t mem [DEPTH];

    // Read returns the stored value; a same-cycle write lands at the edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= BHT_WNT;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= bht_next(mem[wr_idx], wr_taken);
        end
    end

    assign rd_cnt = mem[rd_idx];

endmodule

// File: rtl/branch_ctrl.sv
// Branch prediction lookup plus misprediction redirect and timed flush.
// Define BRANCH_STATS_EN to add stat_branches / stat_mispredicts counters.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEF,
    parameter int unsigned BHT_IDX_W    = BHT_IDX_W_DEF,
    parameter int unsigned FLUSH_CYCLES = FLUSH_CYC_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    branch_ctrl_if.slave    bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
`endif
);
    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    brctl_state_t    state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [XLEN-1:0] rpc_q, rpc_nxt;
    logic            rv_q, rv_nxt;
    logic            flush_q, flush_nxt;

    logic            resolve;
    logic            mispredict;
    bht_cnt_t        rd_cnt;
    logic            unused_bits;

    assign resolve    = bus.ex_valid & bus.ex_branch & (state == IDLE);
    assign mispredict = resolve & (bus.ex_taken != bus.ex_pred_taken);

    bht_array #(
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk      (clk),
        .rstn     (rstn),
        .rd_idx   (bus.if_pc[BHT_IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (resolve),
        .wr_idx   (bus.ex_pc[BHT_IDX_W+1:2]),
        .wr_taken (bus.ex_taken)
    );

    assign bus.if_pred_taken = rd_cnt[1] & bus.if_valid;
    assign unused_bits = ^{bus.if_pc[XLEN-1:BHT_IDX_W+2], bus.if_pc[1:0], rd_cnt[0]};

    // State, counter and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            rpc_q   <= '0;
            rv_q    <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            rpc_q   <= rpc_nxt;
            rv_q    <= rv_nxt;
            flush_q <= flush_nxt;
        end
    end

    // Next state; outputs are decoded from the next state so they are flop-driven
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rpc_nxt   = rpc_q;
        case (state)
            IDLE: begin
                if (mispredict) begin
                    rpc_nxt   = bus.ex_taken ? bus.ex_target : XLEN'(bus.ex_pc + XLEN'(4));
                    state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                cnt_nxt   = CNT_W'(FLUSH_CYCLES - 1);
                state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
            end
            FLUSH: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt <= CNT_W'(1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        rv_nxt    = (state_nxt == REDIRECT);
        flush_nxt = (state_nxt != IDLE);
    end

    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.flush          = flush_q;

`ifdef BRANCH_STATS_EN
    // Free-running event counters, wrap at 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (resolve)    stat_branches    <= stat_branches + 32'd1;
            if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Table-driven bench for branch_ctrl plus hand sequences for reset-in-flush and BHT init.
// Statistics checks are compiled in when BRANCH_STATS_EN is defined.
module tb_branch_ctrl;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    branch_ctrl_if #(.XLEN(32)) bus();

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    branch_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifv;
        logic [31:0] ifpc;
        logic        exv;
        logic        exb;
        logic [31:0] expc;
        logic        expred;
        logic        extk;
        logic [31:0] extgt;
        logic        e_pred;
        logic        e_rv;
        logic [31:0] e_rpc;
        logic        e_fl;
    } vec_t;

    localparam int NV = 23;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic ifv, input logic [31:0] ifpc,
                                input logic exv, input logic exb, input logic [31:0] expc,
                                input logic expred, input logic extk, input logic [31:0] extgt,
                                input logic e_pred, input logic e_rv, input logic [31:0] e_rpc,
                                input logic e_fl);
        vec_t v;
        v.ifv = ifv;     v.ifpc = ifpc;
        v.exv = exv;     v.exb = exb;   v.expc = expc;
        v.expred = expred; v.extk = extk; v.extgt = extgt;
        v.e_pred = e_pred; v.e_rv = e_rv; v.e_rpc = e_rpc; v.e_fl = e_fl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_valid      = 1'b0;
        bus.if_pc         = '0;
        bus.ex_valid      = 1'b0;
        bus.ex_branch     = 1'b0;
        bus.ex_pc         = '0;
        bus.ex_pred_taken = 1'b0;
        bus.ex_taken      = 1'b0;
        bus.ex_target     = '0;
    endtask

    task automatic drive_ex(input logic [31:0] pc, input logic pred, input logic tk,
                            input logic [31:0] tgt);
        bus.ex_valid      = 1'b1;
        bus.ex_branch     = 1'b1;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pred;
        bus.ex_taken      = tk;
        bus.ex_target     = tgt;
    endtask

    task automatic wait_flush_done(input string name);
        int k;
        k = 0;
        while (bus.flush === 1'b1 && k < 10) begin
            step();
            k++;
        end
        check(name, 32'(bus.flush), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        idle_inputs();

        // Directed rows: {if, ex inputs} -> {pred, redirect_valid, redirect_pc, flush}
        vecs[0]  = mk(1, 32'h100, 0,0,32'h0,        0,0,32'h0,    0,0,32'h0,    0);
        vecs[1]  = mk(1, 32'h100, 1,1,32'h100,      1,1,32'h0,    0,0,32'h0,    0);
        vecs[2]  = mk(1, 32'h100, 1,1,32'h100,      1,1,32'h0,    1,0,32'h0,    0);
        vecs[3]  = mk(1, 32'h100, 1,1,32'h100,      1,1,32'h0,    1,0,32'h0,    0);
        vecs[4]  = mk(1, 32'h100, 0,0,32'h0,        0,0,32'h0,    1,0,32'h0,    0);
        vecs[5]  = mk(0, 32'h100, 0,0,32'h0,        0,0,32'h0,    0,0,32'h0,    0);
        vecs[6]  = mk(1, 32'h40,  1,1,32'h40,       0,1,32'h2000, 0,0,32'h0,    0);
        vecs[7]  = mk(1, 32'h40,  0,0,32'h0,        0,0,32'h0,    1,1,32'h2000, 1);
        vecs[8]  = mk(1, 32'h40,  0,0,32'h0,        0,0,32'h0,    1,0,32'h2000, 1);
        vecs[9]  = mk(1, 32'h40,  1,0,32'h40,       0,1,32'h9999, 1,0,32'h2000, 0);
        vecs[10] = mk(1, 32'hFFFFFFFC, 1,1,32'hFFFFFFFC, 1,0,32'h1234, 0,0,32'h2000, 0);
        vecs[11] = mk(0, 32'h0,   0,0,32'h0,        0,0,32'h0,    0,1,32'h0,    1);
        vecs[12] = mk(1, 32'h40,  1,1,32'h40,       1,0,32'h3000, 1,0,32'h0,    1);
        vecs[13] = mk(1, 32'h40,  0,0,32'h0,        0,0,32'h0,    1,0,32'h0,    0);
        vecs[14] = mk(1, 32'h40,  1,1,32'h40,       0,0,32'h0,    1,0,32'h0,    0);
        vecs[15] = mk(1, 32'h40,  0,0,32'h0,        0,0,32'h0,    0,0,32'h0,    0);
        vecs[16] = mk(0, 32'h0,   1,1,32'h80,       0,1,32'h500,  0,0,32'h0,    0);
        vecs[17] = mk(0, 32'h0,   0,0,32'h0,        0,0,32'h0,    0,1,32'h500,  1);
        vecs[18] = mk(0, 32'h0,   0,0,32'h0,        0,0,32'h0,    0,0,32'h500,  1);
        vecs[19] = mk(1, 32'h80,  1,1,32'h80,       1,0,32'h0,    1,0,32'h500,  0);
        vecs[20] = mk(0, 32'h0,   0,0,32'h0,        0,0,32'h0,    0,1,32'h84,   1);
        vecs[21] = mk(0, 32'h0,   0,0,32'h0,        0,0,32'h0,    0,0,32'h84,   1);
        vecs[22] = mk(0, 32'h0,   0,0,32'h0,        0,0,32'h0,    0,0,32'h84,   0);

        // Reset state
        #12;
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_redirect_pc",    bus.redirect_pc,          32'd0);
        check("rst_flush",          32'(bus.flush),           32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // Every index predicts not-taken after reset
        bus.if_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.if_pc = 32'(i) << 2;
            #1;
            check($sformatf("init_pred_idx%0d", i), 32'(bus.if_pred_taken), 32'd0);
        end
        step();

        for (int r = 0; r < NV; r++) begin
            bus.if_valid      = vecs[r].ifv;
            bus.if_pc         = vecs[r].ifpc;
            bus.ex_valid      = vecs[r].exv;
            bus.ex_branch     = vecs[r].exb;
            bus.ex_pc         = vecs[r].expc;
            bus.ex_pred_taken = vecs[r].expred;
            bus.ex_taken      = vecs[r].extk;
            bus.ex_target     = vecs[r].extgt;
            @(negedge clk);
            check($sformatf("row%0d_pred", r),  32'(bus.if_pred_taken),  32'(vecs[r].e_pred));
            check($sformatf("row%0d_rv", r),    32'(bus.redirect_valid), 32'(vecs[r].e_rv));
            check($sformatf("row%0d_rpc", r),   bus.redirect_pc,         vecs[r].e_rpc);
            check($sformatf("row%0d_flush", r), 32'(bus.flush),          32'(vecs[r].e_fl));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of FLUSH
        idle_inputs();
        drive_ex(32'h100, 1'b0, 1'b1, 32'h700);
        step();
        idle_inputs();
        check("mid_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        step();
        check("mid_flush_high",     32'(bus.flush),          32'd1);
        check("mid_flush_rv_low",   32'(bus.redirect_valid), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst_flush",    32'(bus.flush),          32'd0);
        check("async_rst_rpc",      bus.redirect_pc,         32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();

        // BHT re-initialised: all not-taken, and one taken step flips every entry
        bus.if_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bus.if_pc = 32'(i) << 2;
            #1;
            check($sformatf("reinit_pred_idx%0d", i), 32'(bus.if_pred_taken), 32'd0);
        end
        for (int i = 0; i < 64; i++) begin
            drive_ex(32'(i) << 2, 1'b1, 1'b1, 32'h0);
            step();
            bus.ex_valid = 1'b0;
            bus.if_pc    = 32'(i) << 2;
            #1;
            check($sformatf("train_pred_idx%0d", i), 32'(bus.if_pred_taken), 32'd1);
        end
        check("train_no_flush", 32'(bus.flush), 32'd0);

`ifdef BRANCH_STATS_EN
        // Five resolves, two of them mispredicts
        idle_inputs();
        rstn = 1'b0;
        #3;
        check("stat_rst_branches", stat_branches,    32'd0);
        check("stat_rst_mispred",  stat_mispredicts, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        step();
        drive_ex(32'h10, 1'b0, 1'b0, 32'h0);
        step();
        drive_ex(32'h14, 1'b0, 1'b1, 32'h800);
        step();
        idle_inputs();
        wait_flush_done("stat_flush1_done");
        drive_ex(32'h18, 1'b1, 1'b1, 32'h900);
        step();
        drive_ex(32'h1C, 1'b1, 1'b0, 32'h0);
        step();
        idle_inputs();
        wait_flush_done("stat_flush2_done");
        drive_ex(32'h20, 1'b0, 1'b0, 32'h0);
        step();
        idle_inputs();
        step();
        check("stat_branches",    stat_branches,    32'd5);
        check("stat_mispredicts", stat_mispredicts, 32'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
